// File: rtl/axis_pkt_rr_arb_if.sv
// Stream bundle for the packet round-robin arbiter: NUM_CH input streams merged
// into one tagged output stream.
`timescale 1ns/1ps
interface axis_pkt_rr_arb_if #(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int CH_ID_WIDTH = $clog2(NUM_CH)
);
  logic [NUM_CH*DATA_WIDTH-1:0] in_tdata;
  logic [NUM_CH-1:0]            in_tlast;
  logic [NUM_CH-1:0]            in_tvalid;
  logic [NUM_CH-1:0]            in_tready;
  logic [DATA_WIDTH-1:0]        out_tdata;
  logic                         out_tlast;
  logic [CH_ID_WIDTH-1:0]       out_tid;
  logic                         out_tvalid;
  logic                         out_tready;

  // The arbiter is the slave of the input streams and drives the merged output.
  modport slave (
    input  in_tdata, in_tlast, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tlast, out_tid, out_tvalid
  );

  modport master (
    output in_tdata, in_tlast, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tlast, out_tid, out_tvalid
  );
endinterface

// File: rtl/axis_pkt_rr_arb.sv
// Packet-level round-robin arbiter: grants one channel per packet, holds it until
// that channel's tlast is accepted, and tags every output beat with its source.
`timescale 1ns/1ps
module axis_pkt_rr_arb #(
  parameter int NUM_CH      = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int CH_ID_WIDTH = $clog2(NUM_CH)
) (
  input  logic              ap_clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] ch_enable,
  axis_pkt_rr_arb_if.slave  bus,
  output logic              busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 r_state;
  logic [CH_ID_WIDTH-1:0] r_grant;
  logic [CH_ID_WIDTH-1:0] r_last_grant;
  logic [DATA_WIDTH-1:0]  r_out_tdata;
  logic                   r_out_tlast;
  logic [CH_ID_WIDTH-1:0] r_out_tid;
  logic                   r_out_tvalid;

  logic [NUM_CH-1:0]      w_req;
  logic [NUM_CH-1:0]      w_in_tready;
  logic                   w_found;
  logic [CH_ID_WIDTH-1:0] w_cand;
  logic [CH_ID_WIDTH-1:0] w_next_grant;
  logic                   w_accept;

  assign w_req = bus.in_tvalid & ch_enable;

  // Search starts one past the previous winner and wraps, so the last served
  // channel has the lowest priority in the next arbitration.
  always_comb begin
    w_found      = 1'b0;
    w_cand       = '0;
    w_next_grant = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      w_cand = CH_ID_WIDTH'((int'(r_last_grant) + k) % NUM_CH);
      if (!w_found && w_req[w_cand]) begin
        w_found      = 1'b1;
        w_next_grant = w_cand;
      end
    end
  end

  // in_tready is gated by resetn so nothing is accepted while reset is held.
  always_comb begin
    w_in_tready = '0;
    if (resetn && (r_state == BUSY)) begin
      w_in_tready[r_grant] = bus.out_tready | ~r_out_tvalid;
    end
  end

  assign w_accept = (r_state == BUSY) & bus.in_tvalid[r_grant] & w_in_tready[r_grant];

  always_ff @(posedge ap_clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= CH_ID_WIDTH'(NUM_CH - 1);
      r_out_tdata  <= '0;
      r_out_tlast  <= 1'b0;
      r_out_tid    <= '0;
      r_out_tvalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_next_grant;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          if (w_accept && bus.in_tlast[r_grant]) begin
            r_last_grant <= r_grant;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // The output register drains on its own, so a final beat can leave
      // during the following IDLE arbitration cycle.
      if (w_accept) begin
        r_out_tdata  <= bus.in_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH];
        r_out_tlast  <= bus.in_tlast[r_grant];
        r_out_tid    <= r_grant;
        r_out_tvalid <= 1'b1;
      end else if (bus.out_tready) begin
        r_out_tvalid <= 1'b0;
      end
    end
  end

  assign bus.in_tready  = w_in_tready;
  assign bus.out_tdata  = r_out_tdata;
  assign bus.out_tlast  = r_out_tlast;
  assign bus.out_tid    = r_out_tid;
  assign bus.out_tvalid = r_out_tvalid;
  assign busy           = (r_state == BUSY);

endmodule

// File: tb/tb_axis_pkt_rr_arb.sv
// Bench for axis_pkt_rr_arb: per-channel queue-fed sources, a scoreboard of
// hand-computed expected beats and an output monitor that pops and compares.
`timescale 1ns/1ps
module tb_axis_pkt_rr_arb;
  localparam int NUM_CH = 4;
  localparam int DW     = 32;
  localparam int IDW    = 2;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic           last;
    logic [IDW-1:0] id;
  } beat_t;

  logic              ap_clk;
  logic              resetn;
  logic [NUM_CH-1:0] ch_enable;
  logic              busy;

  axis_pkt_rr_arb_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CH_ID_WIDTH(IDW)) bus ();

  axis_pkt_rr_arb #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .CH_ID_WIDTH(IDW)) dut (
    .ap_clk    (ap_clk),
    .resetn    (resetn),
    .ch_enable (ch_enable),
    .bus       (bus),
    .busy      (busy)
  );

  beat_t         srcQ[NUM_CH][$];
  beat_t         expQ[$];
  int            outCyc[$];
  logic          srcValid[NUM_CH];
  logic [DW-1:0] srcData[NUM_CH];
  logic          srcLast[NUM_CH];
  logic          flushReq[NUM_CH];
  int            cycleCount;
  int            assertCount;
  int            failCount;

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    cycleCount = 0;
    forever begin
      @(posedge ap_clk);
      cycleCount++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  always_comb begin
    bus.in_tvalid = '0;
    bus.in_tlast  = '0;
    bus.in_tdata  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.in_tvalid[i]         = srcValid[i];
      bus.in_tlast[i]          = srcLast[i];
      bus.in_tdata[i*DW +: DW] = srcData[i];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h at cycle %0d", name, actual, expected, cycleCount);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic [DW-1:0] base, input int nBeats);
    beat_t b;
    for (int i = 0; i < nBeats; i++) begin
      b.data = base + DW'(i);
      b.last = (i == nBeats - 1);
      b.id   = IDW'(ch);
      srcQ[ch].push_back(b);
    end
  endtask

  task automatic expectBeat(input int ch, input logic [DW-1:0] data, input logic last);
    beat_t b;
    b.data = data;
    b.last = last;
    b.id   = IDW'(ch);
    expQ.push_back(b);
  endtask

  task automatic expectPacket(input int ch, input logic [DW-1:0] base, input int nBeats);
    for (int i = 0; i < nBeats; i++) expectBeat(ch, base + DW'(i), i == nBeats - 1);
  endtask

  task automatic applyReset();
    @(posedge ap_clk); #1;
    resetn = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1 resetn = 1'b1;
  endtask

  function automatic bit allIdle();
    bit idle;
    idle = (expQ.size() == 0) && !busy && !bus.out_tvalid;
    for (int i = 0; i < NUM_CH; i++) idle = idle && (srcQ[i].size() == 0) && !srcValid[i];
    return idle;
  endfunction

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (!allIdle() && n < 300) begin
      @(negedge ap_clk);
      n++;
    end
    checkOutput(name, 32'(n < 300), 32'd1);
  endtask

  // Each channel source presents the next queued beat once the current one is taken.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_src
    initial begin
      logic  accepted;
      beat_t b;
      srcValid[c] = 1'b0;
      srcData[c]  = '0;
      srcLast[c]  = 1'b0;
      forever begin
        @(negedge ap_clk);
        accepted = srcValid[c] && bus.in_tready[c];
        @(posedge ap_clk); #1;
        if (flushReq[c]) begin
          srcQ[c].delete();
          srcValid[c] = 1'b0;
        end else if (accepted || !srcValid[c]) begin
          if (srcQ[c].size() > 0) begin
            b           = srcQ[c].pop_front();
            srcValid[c] = 1'b1;
            srcData[c]  = b.data;
            srcLast[c]  = b.last;
          end else begin
            srcValid[c] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: scoreboard pop on every output handshake plus stall-stability checks.
  initial begin
    beat_t          e;
    logic           prevStall;
    logic [DW-1:0]  pData;
    logic           pLast;
    logic [IDW-1:0] pId;
    prevStall = 1'b0;
    pData     = '0;
    pLast     = 1'b0;
    pId       = '0;
    forever begin
      @(negedge ap_clk);
      if (!resetn) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("holdData", bus.out_tdata, pData);
          checkOutput("holdLast", 32'(bus.out_tlast), 32'(pLast));
          checkOutput("holdTid", 32'(bus.out_tid), 32'(pId));
          checkOutput("holdValid", 32'(bus.out_tvalid), 32'd1);
        end
        if (bus.out_tvalid && !bus.out_tready) checkOutput("stallInReady", 32'(bus.in_tready), 32'd0);
        if (bus.out_tvalid && bus.out_tready) begin
          checkOutput("beatExpected", 32'(expQ.size() > 0), 32'd1);
          if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("outTdata", bus.out_tdata, e.data);
            checkOutput("outTlast", 32'(bus.out_tlast), 32'(e.last));
            checkOutput("outTid", 32'(bus.out_tid), 32'(e.id));
          end
          outCyc.push_back(cycleCount);
        end
        prevStall = bus.out_tvalid && !bus.out_tready;
        pData     = bus.out_tdata;
        pLast     = bus.out_tlast;
        pId       = bus.out_tid;
      end
    end
  end

  initial begin
    logic [15:0] pat;
    int          n;
    assertCount    = 0;
    failCount      = 0;
    resetn         = 1'b0;
    ch_enable      = 4'b0001;
    bus.out_tready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) flushReq[i] = 1'b0;

    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput("rstOutValid", 32'(bus.out_tvalid), 32'd0);
    checkOutput("rstOutLast", 32'(bus.out_tlast), 32'd0);
    checkOutput("rstOutData", bus.out_tdata, 32'd0);
    checkOutput("rstOutTid", 32'(bus.out_tid), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstInReady", 32'(bus.in_tready), 32'd0);
    @(posedge ap_clk); #1 resetn = 1'b1;

    $display("[TB] single channel packet");
    @(negedge ap_clk);
    applyStimulus(0, 32'hA0, 3);
    expectPacket(0, 32'hA0, 3);
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    checkOutput("t1ValidN", 32'(bus.out_tvalid), 32'd0);
    checkOutput("t1BusyN", 32'(busy), 32'd0);
    @(negedge ap_clk);
    checkOutput("t1BusyN1", 32'(busy), 32'd1);
    checkOutput("t1ReadyN1", 32'(bus.in_tready), 32'b0001);
    checkOutput("t1ValidN1", 32'(bus.out_tvalid), 32'd0);
    @(negedge ap_clk);
    checkOutput("t1ValidN2", 32'(bus.out_tvalid), 32'd1);
    @(negedge ap_clk);
    checkOutput("t1BusyN3", 32'(busy), 32'd1);
    @(negedge ap_clk);
    checkOutput("t1BusyN4", 32'(busy), 32'd0);
    waitDrain("t1Drain");

    $display("[TB] round robin fairness");
    ch_enable = 4'hF;
    applyReset();
    @(negedge ap_clk);
    outCyc.delete();
    applyStimulus(0, 32'h000, 2);
    applyStimulus(0, 32'h010, 2);
    applyStimulus(1, 32'h100, 2);
    applyStimulus(1, 32'h110, 2);
    applyStimulus(2, 32'h200, 2);
    applyStimulus(3, 32'h300, 2);
    expectPacket(0, 32'h000, 2);
    expectPacket(1, 32'h100, 2);
    expectPacket(2, 32'h200, 2);
    expectPacket(3, 32'h300, 2);
    expectPacket(0, 32'h010, 2);
    expectPacket(1, 32'h110, 2);
    waitDrain("t2Drain");
    checkOutput("t2BeatCount", 32'(outCyc.size()), 32'd12);
    if (outCyc.size() == 12) begin
      for (int p = 1; p < 6; p++) begin
        checkOutput("t2PktSpacing", 32'(outCyc[2*p] - outCyc[2*p-2]), 32'd3);
        checkOutput("t2BeatSpacing", 32'(outCyc[2*p+1] - outCyc[2*p]), 32'd1);
      end
    end

    $display("[TB] backpressure");
    @(negedge ap_clk);
    applyStimulus(1, 32'h10, 4);
    expectPacket(1, 32'h10, 4);
    pat = 16'b1001_0100_1011_0111;
    for (int i = 0; i < 16; i++) begin
      @(posedge ap_clk); #1;
      bus.out_tready = pat[15-i];
    end
    @(posedge ap_clk); #1 bus.out_tready = 1'b1;
    waitDrain("t3Drain");

    $display("[TB] enable gating");
    @(negedge ap_clk);
    applyStimulus(2, 32'h20, 3);
    applyStimulus(2, 32'h28, 2);
    applyStimulus(3, 32'h38, 2);
    expectPacket(2, 32'h20, 3);
    expectPacket(3, 32'h38, 2);
    n = 0;
    while (!(bus.out_tvalid && bus.out_tid == 2'd2) && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    checkOutput("t4SawCh2", 32'(n < 50), 32'd1);
    @(posedge ap_clk); #1 ch_enable = 4'b1011;
    n = 0;
    while (expQ.size() > 0 && n < 100) begin
      @(negedge ap_clk);
      n++;
    end
    checkOutput("t4FirstTwoDone", 32'(n < 100), 32'd1);
    repeat (5) @(negedge ap_clk);
    checkOutput("t4SkipBusy", 32'(busy), 32'd0);
    checkOutput("t4Ch2StillValid", 32'(bus.in_tvalid[2]), 32'd1);
    checkOutput("t4SkipOutValid", 32'(bus.out_tvalid), 32'd0);
    expectPacket(2, 32'h28, 2);
    @(posedge ap_clk); #1 ch_enable = 4'hF;
    waitDrain("t4Drain");

    $display("[TB] reset mid-packet");
    @(negedge ap_clk);
    applyStimulus(3, 32'h30, 5);
    expectBeat(3, 32'h30, 1'b0);
    expectBeat(3, 32'h31, 1'b0);
    n = 0;
    while (!(bus.out_tvalid && bus.out_tdata == 32'h31) && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    checkOutput("t5SawBeat1", 32'(n < 50), 32'd1);
    @(posedge ap_clk); #1 resetn = 1'b0;
    @(negedge ap_clk);
    checkOutput("t5InReadyInRst", 32'(bus.in_tready), 32'd0);
    flushReq[3] = 1'b1;
    @(posedge ap_clk); #1 resetn = 1'b1;
    #1 flushReq[3] = 1'b0;
    @(negedge ap_clk);
    checkOutput("t5OutValid", 32'(bus.out_tvalid), 32'd0);
    checkOutput("t5OutData", bus.out_tdata, 32'd0);
    checkOutput("t5OutTid", 32'(bus.out_tid), 32'd0);
    checkOutput("t5OutLast", 32'(bus.out_tlast), 32'd0);
    checkOutput("t5Busy", 32'(busy), 32'd0);
    checkOutput("t5InReady", 32'(bus.in_tready), 32'd0);
    checkOutput("t5ScoreboardEmpty", 32'(expQ.size()), 32'd0);
    applyStimulus(3, 32'h40, 2);
    applyStimulus(0, 32'h50, 2);
    expectPacket(0, 32'h50, 2);
    expectPacket(3, 32'h40, 2);
    waitDrain("t5Drain");

    $display("[TB] wrap and single-beat packets");
    @(negedge ap_clk);
    applyStimulus(0, 32'h60, 1);
    applyStimulus(1, 32'h70, 1);
    expectPacket(0, 32'h60, 1);
    expectPacket(1, 32'h70, 1);
    waitDrain("t6Drain");

    repeat (3) @(negedge ap_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
